// File: rtl/alu32_issue_if.sv
// Request, ALU-drive and result signals between the issue stage and its neighbours.
// The slave modport is the issue stage; master is the upstream/ALU/downstream side.
interface alu32_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [7:0]  req_key;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        alu_en;
  logic        alu_clr;
  logic [7:0]  alu_op;
  logic [7:0]  alu_key;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [7:0]  alu_key_out;

  logic        res_valid;
  logic [7:0]  res_key;
  logic [31:0] res_data;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_key, req_a, req_b, alu_out, alu_key_out,
    output req_ready, alu_en, alu_clr, alu_op, alu_key, alu_a, alu_b,
           res_valid, res_key, res_data, busy
  );

  modport master (
    output req_valid, req_op, req_key, req_a, req_b, alu_out, alu_key_out,
    input  req_ready, alu_en, alu_clr, alu_op, alu_key, alu_a, alu_b,
           res_valid, res_key, res_data, busy
  );
endinterface

// File: rtl/alu32_issue.sv
// Issue stage for the 32-bit ALU: request FIFO, single/multi-cycle issue FSM, result strobe.
// Optional issue statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu32_issue #(
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  alu32_issue_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_mul_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MC_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [7:0]       OP_MUL  = 8'h03;
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_MUL
  } state_e;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  key;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remain;
  state_e           state_q, state_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d;
  entry_t           issue_q, issue_d;
  logic             res_valid_q;

  logic   push;
  logic   pop;
  logic   last;
  logic   boundary;
  logic   flag;
  entry_t req_entry;
  entry_t next_head;

  assign req_entry = '{op: bus.req_op, key: bus.req_key, a: bus.req_a, b: bus.req_b};

  assign bus.req_ready = (count_q < DEPTH_C);
  assign push          = bus.req_valid && bus.req_ready;

  // The head stays in the FIFO while it issues; it leaves on its final alu_en cycle.
  assign last     = (state_q == S_ISSUE) || ((state_q == S_MUL) && (mcnt_q == MC_LAST));
  assign pop      = last;
  assign flag     = last;
  assign boundary = (state_q == S_IDLE) || last;

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign remain   = count_q - CNT_W'(pop);
  assign count_d  = remain + CNT_W'(push);

  // An empty queue hands the incoming request straight to the next issue slot.
  assign next_head = (remain != '0) ? mem_q[rd_ptr_d] : req_entry;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    mcnt_d  = mcnt_q;
    issue_d = issue_q;
    if (boundary) begin
      mcnt_d = '0;
      if (count_d != '0) begin
        issue_d = next_head;
        state_d = (next_head.op == OP_MUL) ? S_MUL : S_ISSUE;
      end else begin
        issue_d = '0;
        state_d = S_IDLE;
      end
    end else if (state_q == S_MUL) begin
      mcnt_d = mcnt_q + MC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst || clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      mcnt_q      <= '0;
      issue_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      issue_q     <= issue_d;
      res_valid_q <= flag;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone mark entries valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_entry;
    end
  end

  assign bus.alu_en    = (state_q != S_IDLE);
  assign bus.alu_clr   = clr;
  assign bus.alu_op    = issue_q.op;
  assign bus.alu_key   = issue_q.key;
  assign bus.alu_a     = issue_q.a;
  assign bus.alu_b     = issue_q.b;

  assign bus.res_valid = res_valid_q;
  assign bus.res_key   = bus.alu_key_out;
  assign bus.res_data  = bus.alu_out;
  assign bus.busy      = (count_q != '0) || (state_q != S_IDLE) || flag;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_mul_q, stat_mul_d;

  // Both counters stick at all-ones instead of wrapping.
  assign stat_ops_d = (last && (stat_ops_q != 16'hFFFF)) ? stat_ops_q + 16'd1 : stat_ops_q;
  assign stat_mul_d = ((state_q == S_MUL) && (stat_mul_q != 16'hFFFF)) ? stat_mul_q + 16'd1
                                                                       : stat_mul_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stat_ops_q <= '0;
      stat_mul_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_mul_q <= stat_mul_d;
    end
  end

  assign stat_ops        = stat_ops_q;
  assign stat_mul_cycles = stat_mul_q;
`endif

endmodule
